tape_sequencer: RTL and testbench



---
 rtl/tape_seq_pkg.sv | 35 +++
 rtl/tape_sequencer_rule_table.sv | 36 +++
 rtl/tape_sequencer.sv | 155 +++++++++++++++
 tb/tb_tape_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_seq_pkg.sv
// Shared types and constants for the tape sequencer.
// Rule layout: {halt, next_state, move, write_sym}.
package tape_seq_pkg;

  localparam int RULE_ST_W = 2;
  localparam int RULE_W    = RULE_ST_W + 3;

  localparam int SYM_BIT  = 0;
  localparam int MOVE_BIT = 1;
  localparam int NS_LSB   = 2;
  localparam int HALT_BIT = RULE_ST_W + 2;

  localparam logic MOVE_LEFT  = 1'b0;
  localparam logic MOVE_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  typedef struct packed {
    logic                 halt;
    logic [RULE_ST_W-1:0] next_state;
    logic                 move;
    logic                 write_sym;
  } rule_t;

  function automatic rule_t to_rule(
    input logic [RULE_W-1:0] raw
  );
    return rule_t'(raw);
  endfunction

endpackage

// File: rtl/tape_sequencer_rule_table.sv
// Transition rule register file: one write port, one async read port.
// Every entry resets to a halt rule.
module tape_rule_table
  import tape_seq_pkg::*;
#(
  parameter int AW = RULE_ST_W + 1,
  parameter int DW = RULE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int N = 2 ** AW;
  localparam logic [DW-1:0] RST_VAL =
    {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tape_sequencer.sv
// Rule-driven tape machine controller (IDLE/RUN/DONE).
// Optional SINGLE_STEP_EN adds step_req to gate RUN edges.
module tape_sequencer
  import tape_seq_pkg::*;
#(
  parameter int TAPE_W    = 10,
  parameter int ST_W      = RULE_ST_W,
  parameter int MAX_STEPS = 64,
  parameter int CNT_W     = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TAPE_W-1:0]         tape_in,
  input  logic                      rule_we,
  input  logic [ST_W:0]             rule_addr,
  input  logic [ST_W+2:0]           rule_data,
`ifdef SINGLE_STEP_EN
  input  logic                      step_req,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic                      timeout,
  output logic [TAPE_W-1:0]         tape_out,
  output logic [$clog2(TAPE_W)-1:0] head,
  output logic [CNT_W-1:0]          steps
);

  localparam int HW = $clog2(TAPE_W);
  localparam logic [HW-1:0] HEAD_MAX =
    HW'(TAPE_W - 1);
  localparam logic [CNT_W-1:0] STEP_LIM =
    CNT_W'(MAX_STEPS);

  fsm_e              state_q, state_d;
  logic [TAPE_W-1:0] tape_q, tape_d;
  logic [HW-1:0]     head_q, head_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [ST_W-1:0]   mst_q, mst_d;
  logic              fault_q, fault_d;
  logic              tmo_q, tmo_d;

  logic              adv;
  logic              tbl_we;
  logic [ST_W:0]     rd_addr;
  logic [ST_W+2:0]   rd_raw;
  rule_t             r;
  logic              at_edge;

`ifdef SINGLE_STEP_EN
  assign adv = step_req;
`else
  assign adv = 1'b1;
`endif

  assign tbl_we  = rule_we && (state_q == IDLE);
  assign rd_addr = {mst_q, tape_q[head_q]};

  tape_rule_table #(
    .AW (ST_W + 1),
    .DW (ST_W + 3)
  ) u_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (tbl_we),
    .waddr_i (rule_addr),
    .wdata_i (rule_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_raw)
  );

  assign r = to_rule(rd_raw);

  // Moving off either end faults instead of wrapping.
  assign at_edge =
    ((r.move == MOVE_LEFT)  && (head_q == '0)) ||
    ((r.move == MOVE_RIGHT) && (head_q == HEAD_MAX));

  always_comb begin
    state_d = state_q;
    tape_d  = tape_q;
    head_d  = head_q;
    steps_d = steps_q;
    mst_d   = mst_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tape_d  = tape_in;
          head_d  = '0;
          steps_d = '0;
          mst_d   = '0;
          fault_d = 1'b0;
          tmo_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          if (steps_q == STEP_LIM) begin
            tmo_d   = 1'b1;
            state_d = DONE;
          end else if (r.halt) begin
            state_d = DONE;
          end else begin
            tape_d[head_q] = r.write_sym;
            steps_d = steps_q + 1'b1;
            if (at_edge) begin
              fault_d = 1'b1;
              state_d = DONE;
            end else begin
              head_d = (r.move == MOVE_RIGHT) ?
                       head_q + 1'b1 :
                       head_q - 1'b1;
              mst_d  = r.next_state;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tape_q  <= '0;
      head_q  <= '0;
      steps_q <= '0;
      mst_q   <= '0;
      fault_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tape_q  <= tape_d;
      head_q  <= head_d;
      steps_q <= steps_d;
      mst_q   <= mst_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign fault    = fault_q;
  assign timeout  = tmo_q;
  assign tape_out = tape_q;
  assign head     = head_q;
  assign steps    = steps_q;

endmodule

// File: tb/tb_tape_sequencer.sv
// Scoreboard bench for tape_sequencer.
// Build with SINGLE_STEP_EN to also cover step_req gating.
module tb_tape_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] tape_in = '0;
  logic       rule_we = 1'b0;
  logic [2:0] rule_addr = '0;
  logic [4:0] rule_data = '0;
`ifdef SINGLE_STEP_EN
  logic       step_req = 1'b1;
`endif
  logic       busy, done, fault, timeout;
  logic [9:0] tape_out;
  logic [3:0] head;
  logic [6:0] steps;

  always #5 clk = ~clk;

  tape_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tape_in   (tape_in),
    .rule_we   (rule_we),
    .rule_addr (rule_addr),
    .rule_data (rule_data),
`ifdef SINGLE_STEP_EN
    .step_req  (step_req),
`endif
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .timeout   (timeout),
    .tape_out  (tape_out),
    .head      (head),
    .steps     (steps)
  );

  typedef struct {
    logic [9:0] tape;
    logic [3:0] head;
    logic [6:0] steps;
    logic       fault;
    logic       tmo;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] rules [8];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [4:0] mk(
    input logic h, input logic [1:0] ns,
    input logic mv, input logic sym);
    return {h, ns, mv, sym};
  endfunction

  task automatic prog(input logic [2:0] a,
                      input logic [4:0] d);
    @(negedge clk);
    rule_we = 1'b1;
    rule_addr = a;
    rule_data = d;
    rules[a] = d;
    @(negedge clk);
    rule_we = 1'b0;
  endtask

  task automatic clear_rules();
    for (int i = 0; i < 8; i++) begin
      prog(3'(i), 5'b10000);
    end
  endtask

  function automatic exp_t model(input logic [9:0] t0);
    exp_t e;
    logic [9:0] t;
    logic [1:0] st;
    logic [4:0] r;
    int h, n;
    bit fin;
    t = t0; st = 2'd0; h = 0; n = 0; fin = 0;
    e.fault = 1'b0; e.tmo = 1'b0; e.lat = 0;
    for (int k = 0; k < 100 && !fin; k++) begin
      if (n == 64) begin
        e.tmo = 1'b1; e.lat = n + 1; fin = 1;
      end else begin
        r = rules[{st, t[h]}];
        if (r[4]) begin
          e.lat = n + 1; fin = 1;
        end else begin
          t[h] = r[0];
          n++;
          if ((!r[1] && h == 0) || (r[1] && h == 9)) begin
            e.fault = 1'b1; e.lat = n; fin = 1;
          end else begin
            h = r[1] ? h + 1 : h - 1;
            st = r[3:2];
          end
        end
      end
    end
    e.tape = t;
    e.head = 4'(h);
    e.steps = 7'(n);
    return e;
  endfunction

  task automatic push(input logic [9:0] t,
                      input logic [3:0] h,
                      input logic [6:0] s,
                      input logic f,
                      input logic to,
                      input int lat);
    exp_t e;
    e.tape = t; e.head = h; e.steps = s;
    e.fault = f; e.tmo = to; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic run(input logic [9:0] t,
                     input bit poke,
                     input bit pulse);
    exp_t e;
    int act;
    bit seen;
    bit a;
    act = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    tape_in = t;
`ifdef SINGLE_STEP_EN
    step_req = !pulse;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(posedge clk);
      #1;
`ifdef SINGLE_STEP_EN
      a = step_req;
`else
      a = 1'b1;
`endif
      if (a) act++;
      if (done) seen = 1;
      @(negedge clk);
`ifdef SINGLE_STEP_EN
      step_req = pulse ? ((k + 1) % 3 == 0) : 1'b1;
`endif
      if (poke && k == 2) begin
        start = 1'b1;
        tape_in = 10'h000;
        rule_we = 1'b1;
        rule_addr = 3'd1;
        rule_data = 5'b10000;
      end
      if (poke && k == 3) begin
        start = 1'b0;
        rule_we = 1'b0;
      end
    end
`ifdef SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    chk("done_seen", 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("tape", 32'(tape_out), 32'(e.tape));
      chk("head", 32'(head), 32'(e.head));
      chk("steps", 32'(steps), 32'(e.steps));
      chk("fault", 32'(fault), 32'(e.fault));
      chk("timeout", 32'(timeout), 32'(e.tmo));
      chk("latency", 32'(act), 32'(e.lat));
    end
    @(posedge clk);
    #1;
    chk("done_1cyc", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("hold_tape", 32'(tape_out),
        32'(seen ? e.tape : 10'h0));
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_fault"}, 32'(fault), 32'd0);
    chk({pfx, "_tmo"}, 32'(timeout), 32'd0);
    chk({pfx, "_tape"}, 32'(tape_out), 32'd0);
    chk({pfx, "_head"}, 32'(head), 32'd0);
    chk({pfx, "_steps"}, 32'(steps), 32'd0);
  endtask

  task automatic prog_inc();
    clear_rules();
    prog(3'b001, mk(1'b0, 2'd0, 1'b1, 1'b1));
    prog(3'b000, mk(1'b0, 2'd1, 1'b1, 1'b1));
  endtask

  initial begin
    bit saw;
    logic [9:0] rt;
    exp_t e;
    for (int i = 0; i < 8; i++) rules[i] = 5'b10000;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    push(10'h155, 4'd0, 7'd0, 1'b0, 1'b0, 1);
    run(10'h155, 0, 0);

    prog_inc();
    push(10'h00F, 4'd4, 7'd4, 1'b0, 1'b0, 5);
    run(10'h007, 0, 0);

    clear_rules();
    prog(3'b000, mk(1'b0, 2'd1, 1'b1, 1'b0));
    prog(3'b010, mk(1'b0, 2'd0, 1'b0, 1'b0));
    push(10'h000, 4'd0, 7'd64, 1'b0, 1'b1, 65);
    run(10'h000, 0, 0);

    clear_rules();
    prog(3'b001, mk(1'b0, 2'd0, 1'b1, 1'b1));
    push(10'h3FF, 4'd9, 7'd10, 1'b1, 1'b0, 10);
    run(10'h3FF, 0, 0);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        prog(3'(i), ($urandom_range(0, 5) == 0) ?
             5'b10000 : {1'b0, 4'($urandom)});
      end
      rt = 10'($urandom);
      e = model(rt);
      sb.push_back(e);
      run(rt, 0, 0);
    end

    clear_rules();
    prog(3'b000, mk(1'b0, 2'd1, 1'b1, 1'b0));
    prog(3'b010, mk(1'b0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    tape_in = 10'h0F0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    saw = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rules[i] = 5'b10000;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) saw = 1;
    end
    chk("abort_nodone", 32'(saw), 32'd0);

    prog(3'b001, mk(1'b0, 2'd0, 1'b1, 1'b1));
    push(10'h3FF, 4'd9, 7'd10, 1'b1, 1'b0, 10);
    run(10'h3FF, 1, 0);
    push(10'h3FF, 4'd9, 7'd10, 1'b1, 1'b0, 10);
    run(10'h3FF, 0, 0);

`ifdef SINGLE_STEP_EN
    prog_inc();
    push(10'h00F, 4'd4, 7'd4, 1'b0, 1'b0, 5);
    run(10'h007, 0, 1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
